cpu_alu_seq: RTL and testbench
==============================

Name: cpu_alu_seq

Overview:
Parametrised, registered successor to the CPU's combinational 8-bit ALU.
- Keeps the existing operation set and its flag semantics.
- Adds carry-in arithmetic, rotate-through-carry, iterative unsigned multiply and unsigned divide.
- Uses a start/busy/done handshake to the control unit.
- Sits between the register file and the flags register; the control unit stalls while busy_o is high.

Parameters:
WIDTH, 8, datapath width in bits (legal: 4 to 32).
OP_W, 5, opcode width.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  synchronous, active-high reset.
start_i  in  1  request; accepted only when busy_o=0.
operation_i  in  OP_W  opcode, sampled on accept.
a_i  in  WIDTH  operand A, sampled on accept.
b_i  in  WIDTH  operand B, sampled on accept.
carry_i  in  1  current C flag, for ADC/SBC/ROL/ROR; sampled on accept.
y_o  out  WIDTH  result, or product low half, or quotient.
y_hi_o  out  WIDTH  product high half or remainder; 0 for all other ops.
z_o  out  1  zero flag.
c_o  out  1  carry/borrow flag.
v_o  out  1  overflow flag (divide-by-zero for DIVU).
n_o  out  1  negative flag.
busy_o  out  1  multi-cycle operation in progress.
done_o  out  1  one-cycle pulse; results and flags updated on this same edge.

Behaviour:
- Reset: y_o, y_hi_o, z_o, c_o, v_o, n_o, busy_o and done_o are all 0.
- Reset mid-operation aborts it with no done_o pulse. Operands latched before the reset are discarded.
- Accept: the edge at which start_i=1 and busy_o=0. While busy_o=1, start_i is ignored; it is neither queued nor flagged.
- Outputs hold their values between done_o pulses.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_A, 6 PASS_B, 7 SHL, 8 SHR, 9 INC, 10 DEC
  - 11 ADC, 12 SBC, 13 ROL, 14 ROR, 15 MUL, 16 DIVU
  - 17 MOVE_XA behaves as PASS_A; 18 MOVE_AX behaves as PASS_B.
  - 19 to 31 are undefined.
- Single-cycle ops (0 to 14, 17, 18): on the accept edge, load y_o and flags and set done_o=1. busy_o stays 0. Latency is 1 cycle.
- Undefined opcodes: y_o=0, y_hi_o=0, Z=1, C=V=N=0, done_o pulses.
- Arithmetic uses (WIDTH+1)-bit internal sums; C = bit WIDTH.
  - SUB: C=1 on borrow (a<b).
  - ADC: a+b+carry_i.
  - SBC: a-b-carry_i; C is the borrow.
  - V is signed overflow for ADD/SUB/ADC/SBC, using the same sign rule as the existing ALU.
- SHL: C=a[W-1], zero fill. SHR: C=a[0], zero fill.
- ROL: y={a[W-2:0],carry_i}, C=a[W-1]. ROR: y={carry_i,a[W-1:1]}, C=a[0].
- INC: C=1 iff a=all-ones. DEC: C=1 iff a=0.
- Single-cycle ops other than those above: C=V=0.
- Single-cycle ops: Z=(y_o==0), N=y_o[W-1].
- MUL, unsigned shift-add:
  - Accept edge: busy_o rises and operands are latched. One iteration per edge thereafter.
  - On edge accept+WIDTH: busy_o falls, done_o=1, {y_hi_o,y_o}=a*b.
  - Flags: C=V=(y_hi_o!=0), Z=(full 2W product==0), N=y_hi_o[W-1].
- DIVU, restoring, same timing as MUL: y_o=quotient, y_hi_o=remainder, C=0, V=0, Z=(quotient==0), N=quotient[W-1].
- Divide by zero (b=0 at accept): treated as single-cycle.
  - y_o=all-ones, y_hi_o=a, V=1, C=0, Z=0, N=1.
  - busy_o never rises.
- Operand or operation_i changes during busy_o have no effect.
- A new start_i on the done_o edge's cycle is accepted (back-to-back issue; zero bubble).

Decomposition:
- Opcode defines 0 to 18 plus OP_W go in the shared operations.vh header, extending the existing OP_* names (OP_ADC, OP_SBC, OP_ROL, OP_ROR, OP_MUL, OP_DIVU).
- Sub-module cpu_alu_iter: WIDTH-parametrised shift-add/restoring-divide datapath.
  - Inputs: load, mode, operands. Outputs: lo, hi.
  - Contains its own iteration counter of width clog2(WIDTH+1).
- The top level holds the single-cycle ALU, the handshake FSM (IDLE, ITER) and the output registers.

Test Plan:
- WIDTH=8: ADD a=0x7F, b=0x01 -> next edge y=0x80, V=1, N=1, C=0, Z=0, done pulse, busy never 1.
- SBC a=0x00, b=0x00, carry_i=1 -> y=0xFF, C=1, N=1. ROR a=0x01, carry_i=1 -> y=0x80, C=1.
- MUL a=0xFF, b=0xFF -> busy high 8 cycles, then y_hi=0xFE, y=0x01, C=V=1. Toggle a_i while busy -> same result.
- DIVU a=200, b=7 -> after 8 cycles y=28, y_hi=4. DIVU b=0, a=0x2A -> 1 cycle, y=0xFF, y_hi=0x2A, V=1.
- start_i held high through a MUL -> exactly one done per operation; a second op issued on the done cycle completes with no bubble.
- rst_i asserted at iteration 4 of a MUL -> all outputs 0 next edge, no done; opcode 31 -> y=0, Z=1; WIDTH=16 MUL 0xFFFF*0x0002 -> y_hi=0x0001, y=0xFFFE.

Source files
------------

// File: rtl/cpu_alu_seq_pkg.sv
// Shared opcode map, FSM encodings and flag payload for the sequential ALU.
package cpu_alu_seq_pkg;

    localparam int unsigned OP_ADD     = 0;
    localparam int unsigned OP_SUB     = 1;
    localparam int unsigned OP_AND     = 2;
    localparam int unsigned OP_OR      = 3;
    localparam int unsigned OP_XOR     = 4;
    localparam int unsigned OP_PASS_A  = 5;
    localparam int unsigned OP_PASS_B  = 6;
    localparam int unsigned OP_SHL     = 7;
    localparam int unsigned OP_SHR     = 8;
    localparam int unsigned OP_INC     = 9;
    localparam int unsigned OP_DEC     = 10;
    localparam int unsigned OP_ADC     = 11;
    localparam int unsigned OP_SBC     = 12;
    localparam int unsigned OP_ROL     = 13;
    localparam int unsigned OP_ROR     = 14;
    localparam int unsigned OP_MUL     = 15;
    localparam int unsigned OP_DIVU    = 16;
    localparam int unsigned OP_MOVE_XA = 17;
    localparam int unsigned OP_MOVE_AX = 18;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ITER = 1'b1;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    typedef struct packed {
        logic z;
        logic c;
        logic v;
        logic n;
    } alu_flags_t;

endpackage

// File: rtl/cpu_alu_iter.sv
// Iterative datapath: unsigned shift-add multiply or restoring divide, one step per clock.
module cpu_alu_iter
    import cpu_alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_c,
    output logic [WIDTH-1:0] hi_c,
    output logic             last_c
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_b;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_sub;

    // lo/hi are the values after the step taken on the coming edge
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ge    = w_div_shift >= {1'b0, r_b};
        w_div_sub   = WIDTH'(w_div_shift - {1'b0, r_b});
        if (r_mode == MODE_DIV) begin
            hi_c = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
            lo_c = {r_lo[WIDTH-2:0], w_div_ge};
        end else begin
            hi_c = w_mul_sum[WIDTH:1];
            lo_c = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign last_c = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lo   <= '0;
            r_hi   <= '0;
            r_b    <= '0;
            r_mode <= MODE_MUL;
            r_cnt  <= '0;
        end else if (load_i) begin
            r_lo   <= a_i;
            r_hi   <= '0;
            r_b    <= b_i;
            r_mode <= mode_i;
            r_cnt  <= CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_lo   <= lo_c;
            r_hi   <= hi_c;
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_alu_seq.sv
// Registered ALU with start/busy/done handshake; MUL and DIVU run on cpu_alu_iter.
module cpu_alu_seq
    import cpu_alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OP_W  = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [OP_W-1:0]  operation_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] y_hi_o,
    output logic             z_o,
    output logic             c_o,
    output logic             v_o,
    output logic             n_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned W1  = WIDTH + 1;
    localparam int unsigned MSB = WIDTH - 1;

    logic [0:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_y, w_y_nxt, r_yhi, w_yhi_nxt;
    alu_flags_t       r_flags, w_flags_nxt;
    logic             r_busy, w_busy_nxt, r_done, w_done_nxt, r_is_div, w_is_div_nxt;

    logic             w_is_mul, w_is_div, w_iter_load, w_last;
    logic [WIDTH-1:0] w_iter_lo, w_iter_hi;
    logic             w_add_cin, w_sub_bin, w_v_add, w_v_sub;
    logic [WIDTH:0]   w_add, w_sub, w_inc, w_dec;
    logic [WIDTH-1:0] w_alu_y;
    logic             w_alu_c, w_alu_v;

    assign w_is_mul  = (operation_i == OP_W'(OP_MUL));
    assign w_is_div  = (operation_i == OP_W'(OP_DIVU));
    assign w_add_cin = (operation_i == OP_W'(OP_ADC)) & carry_i;
    assign w_sub_bin = (operation_i == OP_W'(OP_SBC)) & carry_i;

    // Wide sums: bit WIDTH is carry out (or borrow for the subtract forms)
    assign w_add = {1'b0, a_i} + {1'b0, b_i} + W1'(w_add_cin);
    assign w_sub = {1'b0, a_i} - {1'b0, b_i} - W1'(w_sub_bin);
    assign w_inc = {1'b0, a_i} + W1'(1);
    assign w_dec = {1'b0, a_i} - W1'(1);
    assign w_v_add = (a_i[MSB] == b_i[MSB]) && (w_add[MSB] != a_i[MSB]);
    assign w_v_sub = (a_i[MSB] != b_i[MSB]) && (w_sub[MSB] != a_i[MSB]);

    always_comb begin
        w_alu_y = '0;
        w_alu_c = 1'b0;
        w_alu_v = 1'b0;
        case (operation_i)
            OP_W'(OP_ADD), OP_W'(OP_ADC): begin
                w_alu_y = w_add[MSB:0];
                w_alu_c = w_add[WIDTH];
                w_alu_v = w_v_add;
            end
            OP_W'(OP_SUB), OP_W'(OP_SBC): begin
                w_alu_y = w_sub[MSB:0];
                w_alu_c = w_sub[WIDTH];
                w_alu_v = w_v_sub;
            end
            OP_W'(OP_AND): w_alu_y = a_i & b_i;
            OP_W'(OP_OR):  w_alu_y = a_i | b_i;
            OP_W'(OP_XOR): w_alu_y = a_i ^ b_i;
            OP_W'(OP_PASS_A), OP_W'(OP_MOVE_XA): w_alu_y = a_i;
            OP_W'(OP_PASS_B), OP_W'(OP_MOVE_AX): w_alu_y = b_i;
            OP_W'(OP_SHL): begin
                w_alu_y = {a_i[MSB-1:0], 1'b0};
                w_alu_c = a_i[MSB];
            end
            OP_W'(OP_SHR): begin
                w_alu_y = {1'b0, a_i[MSB:1]};
                w_alu_c = a_i[0];
            end
            OP_W'(OP_INC): begin
                w_alu_y = w_inc[MSB:0];
                w_alu_c = w_inc[WIDTH];
            end
            OP_W'(OP_DEC): begin
                w_alu_y = w_dec[MSB:0];
                w_alu_c = w_dec[WIDTH];
            end
            OP_W'(OP_ROL): begin
                w_alu_y = {a_i[MSB-1:0], carry_i};
                w_alu_c = a_i[MSB];
            end
            OP_W'(OP_ROR): begin
                w_alu_y = {carry_i, a_i[MSB:1]};
                w_alu_c = a_i[0];
            end
            default: ;
        endcase
    end

    cpu_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (w_iter_load),
        .mode_i (w_is_div ? MODE_DIV : MODE_MUL),
        .a_i    (a_i),
        .b_i    (b_i),
        .lo_c   (w_iter_lo),
        .hi_c   (w_iter_hi),
        .last_c (w_last)
    );

    // Handshake FSM and result/flag next-state
    always_comb begin
        w_state_nxt  = r_state;
        w_y_nxt      = r_y;
        w_yhi_nxt    = r_yhi;
        w_flags_nxt  = r_flags;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_is_div_nxt = r_is_div;
        w_iter_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_is_mul || (w_is_div && (b_i != '0))) begin
                        w_iter_load  = 1'b1;
                        w_is_div_nxt = w_is_div;
                        w_busy_nxt   = 1'b1;
                        w_state_nxt  = ST_ITER;
                    end else if (w_is_div) begin
                        w_y_nxt     = '1;
                        w_yhi_nxt   = a_i;
                        w_flags_nxt = '{z: 1'b0, c: 1'b0, v: 1'b1, n: 1'b1};
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_y_nxt     = w_alu_y;
                        w_yhi_nxt   = '0;
                        w_flags_nxt = '{z: (w_alu_y == '0), c: w_alu_c, v: w_alu_v, n: w_alu_y[MSB]};
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (w_last) begin
                    w_y_nxt     = w_iter_lo;
                    w_yhi_nxt   = w_iter_hi;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (r_is_div) begin
                        w_flags_nxt = '{z: (w_iter_lo == '0), c: 1'b0, v: 1'b0, n: w_iter_lo[MSB]};
                    end else begin
                        w_flags_nxt = '{z: (w_iter_lo == '0) && (w_iter_hi == '0),
                                        c: (w_iter_hi != '0), v: (w_iter_hi != '0),
                                        n: w_iter_hi[MSB]};
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_y      <= '0;
            r_yhi    <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_y      <= w_y_nxt;
            r_yhi    <= w_yhi_nxt;
            r_flags  <= w_flags_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_is_div <= w_is_div_nxt;
        end
    end

    assign y_o    = r_y;
    assign y_hi_o = r_yhi;
    assign z_o    = r_flags.z;
    assign c_o    = r_flags.c;
    assign v_o    = r_flags.v;
    assign n_o    = r_flags.n;
    assign busy_o = r_busy;
    assign done_o = r_done;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Directed bench for cpu_alu_seq: vector table for 1-cycle ops, hand sequences for MUL/DIVU/reset.
module tb_cpu_alu_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin;
    logic [4:0] op;
    logic [7:0] a, b, y, yhi;
    logic       z, c, v, n, busy, done;

    logic        start16;
    logic [4:0]  op16;
    logic [15:0] a16, b16, y16, yhi16;
    logic        z16, c16, v16, n16, busy16, done16;

    int n_checks = 0;
    int n_errors = 0;

    cpu_alu_seq #(.WIDTH(8), .OP_W(5)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .operation_i(op),
        .a_i(a), .b_i(b), .carry_i(cin), .y_o(y), .y_hi_o(yhi),
        .z_o(z), .c_o(c), .v_o(v), .n_o(n), .busy_o(busy), .done_o(done)
    );

    cpu_alu_seq #(.WIDTH(16), .OP_W(5)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .operation_i(op16),
        .a_i(a16), .b_i(b16), .carry_i(1'b0), .y_o(y16), .y_hi_o(yhi16),
        .z_o(z16), .c_o(c16), .v_o(v16), .n_o(n16), .busy_o(busy16), .done_o(done16)
    );

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] y;
        logic [7:0] yhi;
        logic [3:0] zcvn;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] o, input logic [7:0] aa, input logic [7:0] bb,
                         input logic ci);
        op = o; a = aa; b = bb; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges after the accept edge until done; optionally scrambles operands meanwhile
    task automatic wait_done(input int limit, input bit scramble, output int lat);
        lat = 0;
        while (!done && lat < limit) begin
            if (scramble) begin
                a = ~a; b = b + 8'd3; op = 5'd2;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

        vecs[0]  = '{5'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 8'h00, 4'b0011};
        vecs[1]  = '{5'd1,  8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 4'b0101};
        vecs[2]  = '{5'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 4'b0000};
        vecs[3]  = '{5'd3,  8'hF0, 8'h0F, 1'b0, 8'hFF, 8'h00, 4'b0001};
        vecs[4]  = '{5'd4,  8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 4'b1000};
        vecs[5]  = '{5'd5,  8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 4'b0001};
        vecs[6]  = '{5'd6,  8'h81, 8'h00, 1'b0, 8'h00, 8'h00, 4'b1000};
        vecs[7]  = '{5'd7,  8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 4'b0100};
        vecs[8]  = '{5'd8,  8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 4'b0100};
        vecs[9]  = '{5'd9,  8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 4'b1100};
        vecs[10] = '{5'd10, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 4'b0101};
        vecs[11] = '{5'd11, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 4'b0011};
        vecs[12] = '{5'd12, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h00, 4'b0101};
        vecs[13] = '{5'd13, 8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 4'b1100};
        vecs[14] = '{5'd14, 8'h01, 8'h00, 1'b1, 8'h80, 8'h00, 4'b0101};
        vecs[15] = '{5'd17, 8'h12, 8'h34, 1'b0, 8'h12, 8'h00, 4'b0000};
        vecs[16] = '{5'd18, 8'h12, 8'h34, 1'b0, 8'h34, 8'h00, 4'b0000};
        vecs[17] = '{5'd31, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 4'b1000};
        vecs[18] = '{5'd19, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1000};
        vecs[19] = '{5'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 4'b0010};
        vecs[20] = '{5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 4'b1100};
        vecs[21] = '{5'd16, 8'h2A, 8'h00, 1'b0, 8'hFF, 8'h2A, 4'b0011};
        vecs[22] = '{5'd13, 8'h55, 8'h00, 1'b1, 8'hAB, 8'h00, 4'b0001};
        vecs[23] = '{5'd11, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 4'b1100};

        repeat (3) @(posedge clk);
        #1;
        check("reset8", 64'({y, yhi, z, c, v, n, busy, done}), 64'd0);
        check("reset16", 64'({y16, yhi16, z16, c16, v16, n16, busy16, done16}), 64'd0);
        rst = 1'b0;

        // Single-cycle ops: result, flags and done on the accept edge, busy stays low
        for (int i = 0; i < 24; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d_op%0d", i, vecs[i].op),
                  64'({y, yhi, z, c, v, n, busy, done}),
                  64'({vecs[i].y, vecs[i].yhi, vecs[i].zcvn, 1'b0, 1'b1}));
            @(posedge clk); #1;
            check($sformatf("vec%0d_hold", i), 64'({y, done}), 64'({vecs[i].y, 1'b0}));
        end

        // MUL 0xFF*0xFF with operands scrambled while busy
        issue(5'd15, 8'hFF, 8'hFF, 1'b0);
        check("mul_busy_rise", 64'({busy, done}), 64'b10);
        wait_done(40, 1'b1, lat);
        check("mul_latency", 64'(lat), 64'd8);
        check("mul_result", 64'({y, yhi, z, c, v, n, busy}), 64'({8'h01, 8'hFE, 4'b0111, 1'b0}));

        // DIVU 200/7
        issue(5'd16, 8'd200, 8'd7, 1'b0);
        wait_done(40, 1'b0, lat);
        check("div_latency", 64'(lat), 64'd8);
        check("div_result", 64'({y, yhi, z, c, v, n}), 64'({8'd28, 8'd4, 4'b0000}));

        // start held high through a MUL; ADD presented during busy, taken on the next edge
        op = 5'd15; a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        op = 5'd0; a = 8'd1; b = 8'd2;
        wait_done(40, 1'b0, lat);
        check("held_mul_latency", 64'(lat), 64'd8);
        check("held_mul_result", 64'({y, yhi, z, c, v, n}), 64'({8'd15, 8'd0, 4'b0000}));
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_add", 64'({y, busy, done}), 64'({8'd3, 1'b0, 1'b1}));
        @(posedge clk); #1;
        check("b2b_single_done", 64'(done), 64'd0);

        // Reset at iteration 4 of a MUL aborts it without a done pulse
        issue(5'd15, 8'hFF, 8'hFF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_reset", 64'({y, yhi, z, c, v, n, busy, done}), 64'd0);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("mid_reset_no_done", 64'(ndone), 64'd0);

        // WIDTH=16 MUL 0xFFFF*0x0002
        op16 = 5'd15; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = 0;
        while (!done16 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mul16_latency", 64'(lat), 64'd16);
        check("mul16_result", 64'({y16, yhi16, z16, c16, v16, n16}),
              64'({16'hFFFE, 16'h0001, 4'b0110}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
